// File: rtl/hc165_pkg.sv
// hc165_pkg
//   Shared definitions for the 74HC165 scan scheduler slice.
//   - HC165_W        : width of one chain's parallel code (8 bits)
//   - hc165_state_e  : scan sequencer states (IDLE, SETTLE, START, WAIT, NEXT)
package hc165_pkg;

  localparam int HC165_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_START,
    ST_WAIT,
    ST_NEXT
  } hc165_state_e;

endpackage

// File: rtl/hc165_period_timer.sv
// hc165_period_timer
//   Periodic trigger plus single-bit pending-request latch for the scan
//   scheduler.
//   Ports:
//     clk       in   system clock
//     rst_n     in   synchronous active-low reset
//     enable    in   period counter runs while high, held at 0 while low
//     req_force in   one-cycle request for an immediate scan
//     take      in   sequencer consumes the pending request this cycle
//     pending   out  a scan request is outstanding (includes this cycle's
//                    requests, so an idle sequencer reacts on the next edge)
module hc165_period_timer
  import hc165_pkg::*;
#(
  parameter int PERIOD = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic req_force,
  input  logic take,
  output logic pending
);

  localparam int CW = $clog2(PERIOD);

  logic [CW-1:0] cnt;
  logic          pend_q;
  logic          hit;

  assign hit     = enable && (cnt == CW'(PERIOD - 1));
  // Requests arriving in the cycle the sequencer takes are folded into
  // the scan being started rather than queuing a second one.
  assign pending = pend_q | req_force | hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      pend_q <= 1'b0;
    end else begin
      if (!enable || hit) cnt <= '0;
      else                cnt <= cnt + 1'b1;
      pend_q <= take ? 1'b0 : pending;
    end
  end

endmodule

// File: rtl/hc165_scan_sched.sv
// hc165_scan_sched
//   Shares one hc165_drive reader among N_CH 74HC165 chains behind an
//   external mux. Steps the mux select through every channel, waits for the
//   select to settle, pulses the driver start, stores each returned code in
//   a register bank and flags channels that never answer.
//   Optional feature macro: HC165_CHANGE_IRQ_EN adds o_change_irq, a pulse
//   with o_scan_done when any stored code differed from its previous value.
//   Ports:
//     clk, rst_n      clock, synchronous active-low reset
//     i_enable        enables periodic scans every PERIOD cycles
//     i_force         one-cycle request for an immediate scan
//     i_clr_err       clears o_timeout (a simultaneous new timeout wins)
//     o_start         one-cycle start pulse to the driver
//     i_code_valid    driver data-valid pulse (ignored outside WAIT)
//     i_code          driver data
//     o_sel           mux select of the active chain
//     o_busy          high from scan start until o_scan_done
//     o_scan_done     one-cycle pulse after the last channel is handled
//     o_code_bank     channel k in bits [8k+7:8k], all ones after reset
//     o_timeout       sticky: some channel failed to answer in TIMEOUT cycles
//     o_change_irq    (HC165_CHANGE_IRQ_EN only) code-change pulse
module hc165_scan_sched
  import hc165_pkg::*;
#(
  parameter  int N_CH    = 4,
  parameter  int PERIOD  = 50000,
  parameter  int SETTLE  = 4,
  parameter  int TIMEOUT = 1023,
  localparam int SEL_W   = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_enable,
  input  logic                    i_force,
  input  logic                    i_clr_err,
  output logic                    o_start,
  input  logic                    i_code_valid,
  input  logic [HC165_W-1:0]      i_code,
  output logic [SEL_W-1:0]        o_sel,
  output logic                    o_busy,
  output logic                    o_scan_done,
  output logic [HC165_W*N_CH-1:0] o_code_bank,
  output logic                    o_timeout
`ifdef HC165_CHANGE_IRQ_EN
  ,
  output logic                    o_change_irq
`endif
);

  localparam int SCW = $clog2(SETTLE + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  hc165_state_e   state;
  logic [SCW-1:0] settle_cnt;
  logic [TCW-1:0] wait_cnt;
  logic           pending;
  logic           take;
  int             slot_lsb;
`ifdef HC165_CHANGE_IRQ_EN
  logic           changed;
`endif

  assign take     = (state == ST_IDLE) && pending;
  assign slot_lsb = int'(o_sel) * HC165_W;

  hc165_period_timer #(
    .PERIOD (PERIOD)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (i_enable),
    .req_force (i_force),
    .take      (take),
    .pending   (pending)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      settle_cnt  <= '0;
      wait_cnt    <= '0;
      o_start     <= 1'b0;
      o_sel       <= '0;
      o_busy      <= 1'b0;
      o_scan_done <= 1'b0;
      o_code_bank <= '1;
      o_timeout   <= 1'b0;
`ifdef HC165_CHANGE_IRQ_EN
      changed      <= 1'b0;
      o_change_irq <= 1'b0;
`endif
    end else begin
      o_start     <= 1'b0;
      o_scan_done <= 1'b0;
`ifdef HC165_CHANGE_IRQ_EN
      o_change_irq <= 1'b0;
`endif
      // Clear first so a timeout set later in this block takes priority.
      if (i_clr_err) o_timeout <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (pending) begin
            o_sel      <= '0;
            o_busy     <= 1'b1;
            settle_cnt <= '0;
`ifdef HC165_CHANGE_IRQ_EN
            changed    <= 1'b0;
`endif
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SCW'(SETTLE - 1)) state <= ST_START;
          else                                settle_cnt <= settle_cnt + 1'b1;
        end
        ST_START: begin
          o_start  <= 1'b1;
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_code_valid) begin
            o_code_bank[slot_lsb +: HC165_W] <= i_code;
`ifdef HC165_CHANGE_IRQ_EN
            if (o_code_bank[slot_lsb +: HC165_W] != i_code) changed <= 1'b1;
`endif
            state <= ST_NEXT;
          end else if (wait_cnt == TCW'(TIMEOUT - 1)) begin
            // No answer within TIMEOUT cycles: keep the old slot value.
            o_timeout <= 1'b1;
            state     <= ST_NEXT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_NEXT: begin
          if (o_sel == SEL_W'(N_CH - 1)) begin
            o_scan_done  <= 1'b1;
            o_busy       <= 1'b0;
`ifdef HC165_CHANGE_IRQ_EN
            o_change_irq <= changed;
`endif
            state        <= ST_IDLE;
          end else begin
            o_sel      <= o_sel + 1'b1;
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hc165_scan_sched.sv
// tb_hc165_scan_sched
//   Bench for hc165_scan_sched with N_CH=4, PERIOD=64, SETTLE=4, TIMEOUT=40.
//   A scan-timeline model predicts every output each cycle from the request
//   history and the responder's configured reply latencies; directed steps
//   add literal expectations for the documented scenarios.
module tb_hc165_scan_sched;

  localparam int N   = 4;
  localparam int SET = 4;
  localparam int PER = 64;
  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_enable = 1'b0;
  logic        i_force = 1'b0;
  logic        i_clr_err = 1'b0;
  logic        i_code_valid = 1'b0;
  logic [7:0]  i_code = 8'h00;
  logic        o_start, o_busy, o_scan_done, o_timeout;
  logic [1:0]  o_sel;
  logic [31:0] o_code_bank;
  logic        irq_w;

  hc165_scan_sched #(
    .N_CH(N), .PERIOD(PER), .SETTLE(SET), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_force(i_force),
    .i_clr_err(i_clr_err), .o_start(o_start), .i_code_valid(i_code_valid),
    .i_code(i_code), .o_sel(o_sel), .o_busy(o_busy), .o_scan_done(o_scan_done),
    .o_code_bank(o_code_bank), .o_timeout(o_timeout)
`ifdef HC165_CHANGE_IRQ_EN
    , .o_change_irq(irq_w)
`endif
  );
`ifndef HC165_CHANGE_IRQ_EN
  assign irq_w = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Responder configuration: per-channel code, reply latency, silence.
  logic [7:0] codes [N];
  int         lat   [N];
  bit         noreply [N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_force();
    i_force = 1'b1;
    tick();
    i_force = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input string nm);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < maxc && !seen; k++) begin
      @(negedge clk);
      if (o_scan_done === 1'b1) seen = 1'b1;
    end
    chk(nm, {63'd0, seen}, 64'd1);
  endtask

  // ---------------- scan-timeline model ----------------
  bit         model_on = 1'b0;
  int         en_cnt;
  bit         pend;
  bit         scan_on;
  int         seg [N];
  int         leff [N];
  bit         nr_s [N];
  logic [7:0] cd_s [N];
  int         done_c;
  logic [7:0] mbank [N];
  bit         mtmo, mchg;
  logic       e_busy, e_start, e_done, e_irq;
  logic [1:0] e_sel;

  always @(posedge clk) begin : model_blk
    bit hit, req, idle_prev, tev;
    cyc++;
    if (!rst_n) begin
      model_on = 1'b1;
      en_cnt = 0; pend = 1'b0; scan_on = 1'b0; done_c = 0;
      mtmo = 1'b0; mchg = 1'b0;
      for (int k = 0; k < N; k++) mbank[k] = 8'hFF;
      e_busy = 1'b0; e_start = 1'b0; e_done = 1'b0; e_irq = 1'b0; e_sel = 2'd0;
    end else if (model_on) begin
      hit = 1'b0;
      if (i_enable) begin
        en_cnt++;
        hit = (en_cnt % PER) == 0;
      end else begin
        en_cnt = 0;
      end
      req = i_force || hit;
      idle_prev = !scan_on || ((cyc - 1) >= done_c);
      if (idle_prev && (pend || req)) begin
        pend = 1'b0; mchg = 1'b0; scan_on = 1'b1;
        for (int k = 0; k < N; k++) begin
          nr_s[k] = noreply[k];
          cd_s[k] = codes[k];
          leff[k] = noreply[k] ? (TMO - 1) : lat[k];
          seg[k]  = (k == 0) ? cyc : seg[k-1] + SET + leff[k-1] + 3;
        end
        done_c = seg[N-1] + SET + leff[N-1] + 3;
      end else if (req) begin
        pend = 1'b1;
      end
      tev = 1'b0;
      if (scan_on) begin
        for (int k = 0; k < N; k++) begin
          if (cyc == seg[k] + SET + leff[k] + 2) begin
            if (nr_s[k]) tev = 1'b1;
            else begin
              if (mbank[k] != cd_s[k]) mchg = 1'b1;
              mbank[k] = cd_s[k];
            end
          end
        end
      end
      if (tev) mtmo = 1'b1;
      else if (i_clr_err) mtmo = 1'b0;
      e_start = 1'b0; e_done = 1'b0; e_irq = 1'b0;
      if (scan_on && cyc < done_c) begin
        e_busy = 1'b1;
        for (int k = 0; k < N; k++) if (seg[k] <= cyc) e_sel = 2'(k);
        e_start = (cyc == seg[e_sel] + SET + 1);
      end else if (scan_on && cyc == done_c) begin
        e_busy = 1'b0;
        e_done = 1'b1;
`ifdef HC165_CHANGE_IRQ_EN
        e_irq  = mchg;
`endif
      end else begin
        e_busy = 1'b0;
      end
    end
  end

  // ---------------- compare process + monitors ----------------
  int          n_start = 0;
  int          n_done  = 0;
  logic [15:0] sel_hist = 16'h0;
  logic        last_irq = 1'b0;
  logic        busy_d = 1'b0;
  int          rises[$];

  always @(negedge clk) begin
    if (model_on) begin
      chk("ctrl{busy,sel,start,done,tmo,irq}",
          {56'd0, o_busy, o_sel, o_start, o_scan_done, o_timeout, irq_w},
          {56'd0, e_busy, e_sel, e_start, e_done, mtmo, e_irq});
      chk("bank", {32'd0, o_code_bank}, {32'd0, mbank[3], mbank[2], mbank[1], mbank[0]});
      if (o_start === 1'b1) begin
        n_start++;
        sel_hist = {sel_hist[11:0], 2'b00, o_sel};
      end
      if (o_scan_done === 1'b1) begin
        n_done++;
        last_irq = irq_w;
      end
      if (o_busy === 1'b1 && busy_d !== 1'b1) rises.push_back(cyc);
      busy_d = o_busy;
    end
  end

  // ---------------- driver responder ----------------
  initial begin : responder
    int ch;
    forever begin
      @(negedge clk);
      if (o_start === 1'b1) begin
        ch = int'(o_sel);
        if (!noreply[ch]) begin
          repeat (lat[ch]) @(posedge clk);
          #1;
          i_code_valid = 1'b1;
          i_code = codes[ch];
          @(posedge clk);
          #1;
          i_code_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int s0, d0, t;
    bit found;
    codes[0] = 8'h11; codes[1] = 8'h22; codes[2] = 8'h33; codes[3] = 8'h44;
    lat[0] = 1; lat[1] = 2; lat[2] = 3; lat[3] = 1;
    for (int k = 0; k < N; k++) noreply[k] = 1'b0;

    repeat (3) tick();
    chk("reset_busy", {63'd0, o_busy}, 64'd0);
    chk("reset_sel", {62'd0, o_sel}, 64'd0);
    chk("reset_bank", {32'd0, o_code_bank}, 64'hFFFF_FFFF);
    chk("reset_timeout", {63'd0, o_timeout}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Valid while idle must be ignored.
    i_code_valid = 1'b1; i_code = 8'h00;
    tick();
    i_code_valid = 1'b0;
    tick();
    chk("stray_valid_ignored", {32'd0, o_code_bank}, 64'hFFFF_FFFF);

    // Forced scan, codes 11/22/33/44.
    s0 = n_start; d0 = n_done; sel_hist = 16'h0;
    pulse_force();
    chk("force_to_busy", {63'd0, o_busy}, 64'd1);
    t = 0;
    while (o_start !== 1'b1 && t < 20) begin tick(); t++; end
    chk("busy_to_start_cycles", t, SET + 1);
    wait_done(200, "scan1_done");
    tick();
    chk("scan1_bank", {32'd0, o_code_bank}, 64'h4433_2211);
    chk("scan1_starts", n_start - s0, 4);
    chk("scan1_sel_seq", {48'd0, sel_hist}, 64'h0123);
    chk("scan1_done_count", n_done - d0, 1);
    chk("scan1_busy_low", {63'd0, o_busy}, 64'd0);

    // Channel 2 silent: timeout, slot 2 keeps 0x33, channel 3 still scanned.
    codes[0] = 8'h55; codes[1] = 8'h66; codes[2] = 8'h77; codes[3] = 8'h88;
    noreply[2] = 1'b1;
    pulse_force();
    wait_done(300, "timeout_scan_done");
    tick();
    chk("timeout_bank", {32'd0, o_code_bank}, 64'h8833_6655);
    chk("timeout_flag_set", {63'd0, o_timeout}, 64'd1);
    i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;
    chk("timeout_flag_cleared", {63'd0, o_timeout}, 64'd0);
    noreply[2] = 1'b0;

    // Three extra forces during a scan collapse into one follow-up scan.
    s0 = n_start; d0 = n_done;
    pulse_force();
    repeat (5) tick();
    pulse_force();
    repeat (5) tick();
    pulse_force();
    repeat (5) tick();
    pulse_force();
    chk("collapse_still_busy", {63'd0, o_busy}, 64'd1);
    wait_done(200, "collapse_scan_a");
    wait_done(200, "collapse_scan_b");
    repeat (100) tick();
    chk("collapse_done_count", n_done - d0, 2);
    chk("collapse_start_count", n_start - s0, 8);

    // Periodic scanning with instant replies: no drift over 10 periods.
    for (int k = 0; k < N; k++) lat[k] = 1;
    rises.delete();
    i_enable = 1'b1;
    repeat (10 * PER + 20) tick();
    i_enable = 1'b0;
    wait_done(200, "period_last_scan_done");
    tick();
    chk("period_scan_count", rises.size(), 10);
    for (int i = 1; i < rises.size(); i++)
      chk("period_spacing", rises[i] - rises[i-1], PER);
    lat[0] = 1; lat[1] = 10; lat[2] = 3; lat[3] = 1;

    // Reset while waiting on channel 1.
    pulse_force();
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (o_start === 1'b1 && o_sel === 2'd1) found = 1'b1;
    end
    chk("reached_wait_ch1", {63'd0, found}, 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_busy", {63'd0, o_busy}, 64'd0);
    chk("midrst_sel", {62'd0, o_sel}, 64'd0);
    chk("midrst_bank", {32'd0, o_code_bank}, 64'hFFFF_FFFF);
    chk("midrst_timeout", {63'd0, o_timeout}, 64'd0);
    s0 = n_start;
    repeat (40) tick();
    chk("midrst_no_start", n_start - s0, 0);
    chk("midrst_late_valid_ignored", {32'd0, o_code_bank}, 64'hFFFF_FFFF);
    lat[1] = 2;

`ifdef HC165_CHANGE_IRQ_EN
    codes[0] = 8'h01; codes[1] = 8'h02; codes[2] = 8'h03; codes[3] = 8'h04;
    pulse_force();
    wait_done(200, "irq_base_done");
    tick();
    chk("irq_base_vs_ones", {63'd0, last_irq}, 64'd1);
    pulse_force();
    wait_done(200, "irq_same1_done");
    tick();
    chk("irq_same1", {63'd0, last_irq}, 64'd0);
    pulse_force();
    wait_done(200, "irq_same2_done");
    tick();
    chk("irq_same2", {63'd0, last_irq}, 64'd0);
    codes[0] = 8'h5A;
    pulse_force();
    wait_done(200, "irq_change_done");
    tick();
    chk("irq_change", {63'd0, last_irq}, 64'd1);
    chk("irq_change_bank", {32'd0, o_code_bank}, 64'h0403_025A);
`endif

    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
